// File: rtl/fpu_sequencer.sv
// fpu_sequencer: issue-side sequencer in front of the FPU controller.
// Takes one req/op/operand set, walks the controller's operand and result
// handshakes, and returns the result with a one-cycle done pulse.
// Optional feature: `define FPU_SEQ_TIMEOUT_EN adds a per-transaction cycle
// budget (TIMEOUT_CYCLES) that ends a stuck transaction with err=1.
module fpu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  output logic [3:0]  fpu_op,
  output logic [31:0] fpu_in1,
  output logic [31:0] fpu_in2,
  output logic        fpu_in1_stb,
  output logic        fpu_in2_stb,
  input  logic        fpu_in1_ack,
  input  logic        fpu_in2_ack,
  input  logic [31:0] fpu_out,
  input  logic        fpu_out_stb,
  output logic        fpu_out_ack
);

  localparam logic [3:0] OP_LAST_VALID = 4'd10;
  localparam logic [3:0] OP_FCVT_S_W   = 4'd4;
  localparam logic [3:0] OP_FCVT_W_S   = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_WAIT_RES,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_bad_op;
  logic        r_stb;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_out_ack;
  logic [31:0] r_result;
  logic [31:0] r_in1;
  logic [31:0] r_in2;
  logic [3:0]  r_op;

  logic        w_valid_req_op;
  logic        w_single_op;
  logic        w_timeout;

  assign w_valid_req_op = (req_op <= OP_LAST_VALID);
  assign w_single_op    = (r_op == OP_FCVT_S_W) || (r_op == OP_FCVT_W_S);

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last_cycle;

  assign w_last_cycle = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Budget expires only when the awaited handshake has not arrived this cycle
  always_comb begin
    w_timeout = 1'b0;
    case (r_state)
      S_SEND_A:   w_timeout = w_last_cycle && !r_bad_op && !fpu_in1_ack;
      S_SEND_B:   w_timeout = w_last_cycle && !fpu_in2_ack;
      S_WAIT_RES: w_timeout = w_last_cycle && !fpu_out_stb;
      default:    w_timeout = 1'b0;
    endcase
  end

  // Per-transaction cycle counter, cleared while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (r_state != S_DONE) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Sequencer FSM; every output is a register updated with the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_bad_op  <= 1'b0;
      r_stb     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_out_ack <= 1'b0;
      r_result  <= '0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_op      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_op     <= req_op;
            r_in1    <= req_a;
            r_in2    <= req_b;
            r_busy   <= 1'b1;
            // invalid ops sit one cycle in SEND_A with strobes held low
            r_bad_op <= !w_valid_req_op;
            r_stb    <= w_valid_req_op;
            r_state  <= S_SEND_A;
          end
        end
        S_SEND_A: begin
          if (r_bad_op) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (fpu_in1_ack) begin
            if (w_single_op) begin
              r_stb     <= 1'b0;
              r_out_ack <= 1'b1;
              r_state   <= S_WAIT_RES;
            end else begin
              r_state   <= S_SEND_B;
            end
          end
        end
        S_SEND_B: begin
          if (fpu_in2_ack) begin
            r_stb     <= 1'b0;
            r_out_ack <= 1'b1;
            r_state   <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          if (fpu_out_stb) begin
            r_result  <= fpu_out;
            r_err     <= 1'b0;
            r_out_ack <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_bad_op <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_timeout) begin
        r_stb     <= 1'b0;
        r_out_ack <= 1'b0;
        r_result  <= '0;
        r_err     <= 1'b1;
        r_done    <= 1'b1;
        r_state   <= S_DONE;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign err         = r_err;
  assign fpu_op      = r_op;
  assign fpu_in1     = r_in1;
  assign fpu_in2     = r_in2;
  assign fpu_in1_stb = r_stb;
  assign fpu_in2_stb = r_stb;
  assign fpu_out_ack = r_out_ack;

endmodule
